// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and types for the 4x4 matrix loader
package matrix_pkg;

    localparam int W         = 12;
    localparam int N         = 4;
    localparam int FRAME_LEN = 32;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef logic [N-1:0][W-1:0] col_t;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

endpackage

// File: rtl/matrix_4x4_bank.sv
// rtl/matrix_4x4_bank.sv - one storage bank holding an A/B matrix pair
module matrix_4x4_bank import matrix_pkg::*; #(
    parameter int W = matrix_pkg::W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en_i,
    input  logic [IDX_W-1:0]            idx_i,
    input  logic [W-1:0]                data_i,
    input  logic                        last_i,
    input  logic                        release_i,
    output logic [N-1:0][N-1:0][W-1:0]  a_o,
    output logic [N-1:0][N-1:0][W-1:0]  b_o
);

    bank_state_e                 state_q, state_d;
    logic [N-1:0][N-1:0][W-1:0]  a_q, b_q;
    logic                        commit, abort, write;

    assign commit = wr_en_i && (idx_i == LAST_IDX);
    assign abort  = wr_en_i && last_i && (idx_i != LAST_IDX);
    assign write  = wr_en_i && (state_q != BANK_FULL);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BANK_EMPTY:   if (wr_en_i && !abort) state_d = BANK_FILLING;
            BANK_FILLING: begin
                if (commit)     state_d = BANK_FULL;
                else if (abort) state_d = BANK_EMPTY;
            end
            BANK_FULL:    if (release_i) state_d = BANK_EMPTY;
            default:      state_d = BANK_EMPTY;
        endcase
    end

    // idx bit 4 selects A/B, bits 3:2 the column, bits 1:0 the row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BANK_EMPTY;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (write) begin
                if (idx_i[4]) b_q[idx_i[3:2]][idx_i[1:0]] <= data_i;
                else          a_q[idx_i[3:2]][idx_i[1:0]] <= data_i;
            end
        end
    end

    assign a_o = a_q;
    assign b_o = b_q;

endmodule

// File: rtl/matrix_4x4_loader.sv
// rtl/matrix_4x4_loader.sv - ping-pong loader streaming A/B frames into a 4x4 compute stage
module matrix_4x4_loader import matrix_pkg::*; #(
    parameter int W = matrix_pkg::W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W-1:0]      s_data,
    input  logic              s_last,
    output logic [3:0][W-1:0] aC1,
    output logic [3:0][W-1:0] aC2,
    output logic [3:0][W-1:0] aC3,
    output logic [3:0][W-1:0] aC4,
    output logic [3:0][W-1:0] bC1,
    output logic [3:0][W-1:0] bC2,
    output logic [3:0][W-1:0] bC3,
    output logic [3:0][W-1:0] bC4,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              err
);

    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             err_q, err_d;

    logic accept, at_last, commit, abort, hs;

    logic [N-1:0][N-1:0][W-1:0] a_bank [2];
    logic [N-1:0][N-1:0][W-1:0] b_bank [2];

    assign s_ready   = (cnt_q < 2'd2);
    assign valid_out = (cnt_q != 2'd0);
    assign err       = err_q;

    assign accept  = s_valid && s_ready;
    assign at_last = (k_q == LAST_IDX);
    assign commit  = accept && at_last;
    assign abort   = accept && s_last && !at_last;
    assign hs      = valid_out && ready_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        err_d    = err_q;

        if (accept) k_d = (at_last || s_last) ? '0 : k_q + 1'b1;
        if (commit) wr_ptr_d = ~wr_ptr_q;
        if (hs)     rd_ptr_d = ~rd_ptr_q;

        // a commit and a release in the same cycle cancel out
        unique case ({commit, hs})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        if (abort || (commit && !s_last)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            k_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            err_q    <= err_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        matrix_4x4_bank #(.W(W)) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (accept && (wr_ptr_q == 1'(g))),
            .idx_i     (k_q),
            .data_i    (s_data),
            .last_i    (s_last),
            .release_i (hs && (rd_ptr_q == 1'(g))),
            .a_o       (a_bank[g]),
            .b_o       (b_bank[g])
        );
    end

    // the read bank is never the write target while presented, so outputs hold
    assign aC1 = a_bank[rd_ptr_q][0];
    assign aC2 = a_bank[rd_ptr_q][1];
    assign aC3 = a_bank[rd_ptr_q][2];
    assign aC4 = a_bank[rd_ptr_q][3];
    assign bC1 = b_bank[rd_ptr_q][0];
    assign bC2 = b_bank[rd_ptr_q][1];
    assign bC3 = b_bank[rd_ptr_q][2];
    assign bC4 = b_bank[rd_ptr_q][3];

endmodule

// File: tb/tb_matrix_4x4_loader.sv
// tb/tb_matrix_4x4_loader.sv - scoreboard bench for matrix_4x4_loader
module tb_matrix_4x4_loader;

    logic              clk = 1'b0;
    logic              rst_n, s_valid, s_last, ready_in;
    logic              s_ready, valid_out, err;
    logic [11:0]       s_data;
    logic [3:0][11:0]  aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [383:0] sb_q [$];
    logic [11:0]  fr [32];
    int cons_mode, pulse_req, pulse_done, hs_cnt, commit_cnt;
    bit gap_en, prod_done;

    always #5 clk = ~clk;

    matrix_4x4_loader dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last),
        .aC1(aC1), .aC2(aC2), .aC3(aC3), .aC4(aC4),
        .bC1(bC1), .bC2(bC2), .bC3(bC3), .bC4(bC4),
        .valid_out(valid_out), .ready_in(ready_in), .err(err)
    );

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] flat();
        return {aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4};
    endfunction

    // element k: A for k<16, column (k%16)/4, row k%4
    function automatic logic [383:0] model();
        logic [3:0][11:0] ea [4];
        logic [3:0][11:0] eb [4];
        for (int k = 0; k < 32; k++) begin
            int c = (k % 16) / 4;
            int r = k % 4;
            if (k < 16) ea[c][r] = fr[k];
            else        eb[c][r] = fr[k];
        end
        return {ea[0], ea[1], ea[2], ea[3], eb[0], eb[1], eb[2], eb[3]};
    endfunction

    task automatic fill_ramp(input int base);
        for (int k = 0; k < 32; k++) fr[k] = 12'(base + k);
    endtask

    task automatic send_elem(input logic [11:0] d, input logic last);
        int t = 0;
        if (gap_en && $urandom_range(3, 0) == 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = d; s_last = last;
        while (!s_ready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) check("s_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_range(input int lo, input int hi, input int last_idx);
        for (int k = lo; k <= hi; k++) begin
            send_elem(fr[k], k == last_idx);
            if (k == 31) begin
                sb_q.push_back(model());
                commit_cnt++;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (!(sb_q.size() == 0 && !valid_out) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) check("drain_timeout", 0, 1);
    endtask

    // consumer: drives ready_in at negedge, pops scoreboard on each handshake
    initial begin
        logic [383:0] snap;
        logic pv, ph;
        pv = 1'b0; ph = 1'b0; snap = '0;
        ready_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) pv = 1'b0;
            else if (pv && !ph) check("hold_stable", flat(), snap);
            ready_in = (cons_mode == 1) || (cons_mode == 2 && $urandom_range(1, 0) == 1);
            if (pulse_req != pulse_done) begin
                ready_in = 1'b1;
                pulse_done++;
            end
            #1;
            ph = valid_out && ready_in && rst_n;
            if (ph) begin
                hs_cnt++;
                if (sb_q.size() == 0) check("sb_underflow", 1, 0);
                else                  check("pair_data", flat(), sb_q.pop_front());
            end
            pv   = valid_out && rst_n;
            snap = flat();
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, h0, t;
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        cons_mode = 0; pulse_req = 0; pulse_done = 0; hs_cnt = 0; commit_cnt = 0;
        gap_en = 1'b0; prod_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_valid_out", valid_out, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_err", err, 0);
        check("rst_data", flat(), 0);

        // frame with s_data = k+1, consumer stalled
        fill_ramp(1);
        send_range(0, 30, -1);
        check("s1_valid_before_last", valid_out, 0);
        send_range(31, 31, 31);
        check("s1_valid_rise", valid_out, 1);
        check("s1_aC1_0", aC1[0], 1);
        check("s1_aC2_0", aC2[0], 5);
        check("s1_bC1_0", bC1[0], 17);
        check("s1_bC4_3", bC4[3], 32);
        check("s1_err", err, 0);
        cons_mode = 1;
        wait_drain();
        cons_mode = 0;

        // three back-to-back frames against a stalled consumer
        c0 = commit_cnt;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    fill_ramp(100 * (f + 1));
                    send_range(0, 31, 31);
                end
                prod_done = 1'b1;
            end
        join_none
        t = 0;
        while (commit_cnt < c0 + 2 && t < 300) begin
            @(posedge clk); #3;
            t++;
        end
        check("s2_two_frames_timeout", t < 300, 1);
        check("s2_s_ready_low", s_ready, 0);
        check("s2_frame1_shown", flat(), sb_q[0]);
        repeat (5) @(posedge clk);
        #3;
        check("s2_frame1_still", flat(), sb_q[0]);
        pulse_req++;
        @(posedge clk); #3;
        check("s2_valid_after_pulse", valid_out, 1);
        check("s2_frame2_shown", flat(), sb_q[0]);
        check("s2_s_ready_back", s_ready, 1);
        cons_mode = 1;
        t = 0;
        while (!prod_done && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("s2_prod_timeout", t < 300, 1);
        wait_drain();
        cons_mode = 0;

        // commit of frame 2 coincides with release of frame 1
        fill_ramp(500);
        send_range(0, 31, 31);
        fill_ramp(700);
        send_range(0, 30, -1);
        h0 = hs_cnt;
        pulse_req++;
        send_range(31, 31, 31);
        check("s3_s_ready", s_ready, 1);
        check("s3_valid", valid_out, 1);
        check("s3_frame2_shown", flat(), model());
        check("s3_one_hs", hs_cnt, h0 + 1);
        cons_mode = 1;
        wait_drain();

        // early s_last at k=10
        fill_ramp(900);
        send_range(0, 10, 10);
        check("s4_err_set", err, 1);
        check("s4_no_valid", valid_out, 0);
        check("s4_s_ready", s_ready, 1);
        fill_ramp(1200);
        send_range(0, 31, 31);
        wait_drain();
        check("s4_err_sticky", err, 1);

        // reset mid-frame at k=20 with a pair presented
        cons_mode = 0;
        fill_ramp(1500);
        send_range(0, 31, 31);
        fill_ramp(1700);
        send_range(0, 19, -1);
        s_valid = 1'b1; s_data = fr[20]; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; s_valid = 1'b0;
        sb_q.delete();
        check("s5_valid_out", valid_out, 0);
        check("s5_s_ready", s_ready, 1);
        check("s5_data_zero", flat(), 0);
        check("s5_err_clear", err, 0);
        // missing s_last still commits and flags err
        fill_ramp(2000);
        send_range(0, 31, -1);
        check("s5_missing_last_err", err, 1);
        check("s5_valid", valid_out, 1);
        check("s5_frame_shown", flat(), model());
        cons_mode = 1;
        wait_drain();

        // identity A then random frames, random gaps and random consumer
        c0 = commit_cnt; h0 = hs_cnt;
        cons_mode = 2; gap_en = 1'b1;
        for (int k = 0; k < 32; k++)
            fr[k] = (k < 16) ? (((k / 4) == (k % 4)) ? 12'd1024 : 12'd0) : 12'($urandom);
        send_range(0, 31, 31);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 32; k++) fr[k] = 12'($urandom);
            send_range(0, 31, 31);
        end
        wait_drain();
        check("s6_hs_per_frame", hs_cnt - h0, commit_cnt - c0);
        check("s6_frames", commit_cnt - c0, 3);
        check("end_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_4x4_loader.md
MATRIX_4X4_LOADER -- requirements
Module: matrix_4x4_loader

Interface
REQ-001 Parameter W, default 12, element width in fixed-point 12:10 format, shared with the downstream 4x4 compute stage.
REQ-002 clk  input  1  single clock for all logic; everything is sampled on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 s_valid  input  1  upstream element valid.
REQ-005 s_ready  output  1  loader can accept an element.
REQ-006 s_data  input  W  matrix element, fixed-point 12:10.
REQ-007 s_last  input  1  marks the final element (index 31) of an A/B frame.
REQ-008 aC1..aC4  output  [3:0][W-1:0] each  columns of matrix A; index [r] is row r.
REQ-009 bC1..bC4  output  [3:0][W-1:0] each  columns of matrix B; index [r] is row r.
REQ-010 valid_out  output  1  an A/B pair is presented; connects to the compute stage's valid_in.
REQ-011 ready_in  input  1  consumer done with the presented pair; connects to the compute stage's ready_out.
REQ-012 err  output  1  sticky framing error flag.

Function
REQ-013 A frame shall be 32 elements, with element index k in 0..31: k<16 goes to A, k>=16 goes to B; the column is c=(k mod 16)/4 and the row is r=k mod 4; the element is written to xC(c+1)[r].
REQ-014 The loader shall contain two storage banks (ping-pong), each holding one full A/B pair, plus a write-bank pointer, a read-bank pointer and a full count of 0..2.
REQ-015 s_ready shall be 1 whenever the full count is below 2, combinationally from registered state.
REQ-016 An element shall be accepted on s_valid && s_ready, with throughput of one element per cycle and no bubbles.
REQ-017 On acceptance at k=31, the write bank shall become full, the full count shall increment, the write pointer shall toggle, and k shall return to 0.
REQ-018 valid_out shall be 1 whenever the full count is above 0; the outputs shall show the read bank.
REQ-019 valid_out shall rise one cycle after the cycle in which element 31 is accepted, when the full count was 0.
REQ-020 While valid_out=1, the aC*/bC* outputs shall hold stable until the handshake, because the consumer reads them combinationally across many cycles.
REQ-021 On valid_out && ready_in, the read pointer shall toggle and the full count shall decrement; the next bank, if full, shall be presented in the following cycle.
REQ-022 Acceptance of element 31 and a consumer handshake in the same cycle shall leave the full count unchanged and toggle both pointers.
REQ-023 ready_in while valid_out=0 shall be ignored.
REQ-024 Early s_last (accepted at k<31) shall discard the partial frame, reset k to 0, set err, and leave the full count unchanged.
REQ-025 Missing s_last at k=31 shall still commit the frame and shall set err.
REQ-026 err shall be cleared only by reset.
REQ-027 Data shall be stored verbatim, with no arithmetic and no width conversion.
REQ-028 Per-bank state machine: EMPTY -> FILLING on the first accepted element; FILLING -> FULL at k=31; FULL -> EMPTY on the handshake; FILLING -> EMPTY on early s_last.

Reset
REQ-029 With rst_n=0 at a clock edge, the block shall load: full count 0, both pointers 0, k=0, all bank contents 0, err=0.
REQ-030 Resulting reset outputs shall be: valid_out=0, s_ready=1, all aC*/bC* equal to 0.
REQ-031 Reset mid-frame or while a pair is presented shall discard all stored data, with no partial output.

Structure
REQ-032 Package matrix_pkg shall hold W, N=4, FRAME_LEN=32, typedef col_t ([3:0][W-1:0]), and the bank-state enum.
REQ-033 One sub-module, matrix_4x4_bank, shall be instantiated twice; it holds one A/B pair, a write enable, and the element index.
REQ-034 Target implementation size is 120-400 lines of RTL.

Verification
REQ-035 Scenario 1: after reset, stream k=0..31 with s_data=k+1 and s_last at k=31 -> valid_out rises at cycle 33; aC1[0]=1, aC2[0]=5, bC1[0]=17, bC4[3]=32; err=0.
REQ-036 Scenario 2: hold ready_in=0 and stream 3 frames back to back -> s_ready falls after frame 2; frame 1 outputs stay stable; on one ready_in pulse, frame 2 is presented the next cycle and s_ready returns to 1.
REQ-037 Scenario 3: element 31 of frame 2 arrives in the same cycle as ready_in for frame 1 -> full count stays 1; frame 2 is presented the next cycle; no data is lost.
REQ-038 Scenario 4: s_last at k=10 -> err=1; the partial frame is dropped; the next full 32-element frame loads correctly; err stays 1.
REQ-039 Scenario 5: rst_n=0 for one cycle mid-frame at k=20 with a pair presented -> valid_out=0, outputs are 0, s_ready=1; a subsequent frame starts at k=0.
REQ-040 Scenario 6: connected to the 4x4 compute stage, load A=identity (1024 on the diagonal) and B=arbitrary -> the compute stage is held stable until its ready_out, and exactly one handshake occurs per frame.
